// File: rtl/dbg_run_controller_pkg.sv
// dbg_run_controller_pkg: shared state encodings and default widths for the Nibbler run controller
package dbg_run_controller_pkg;
  localparam int ST_W = 2;
  localparam int PC_W_DEF = 12;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [ST_W-1:0] {HALT = 2'd0, RUN = 2'd1, FINISH = 2'd2} state_t;
endpackage

// File: rtl/dbg_run_controller_if.sv
// dbg_run_controller_if: debug requests, core observation and run-control outputs
interface dbg_run_controller_if
  import dbg_run_controller_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic run;
  logic halt;
  logic step;
  logic bp_en;
  logic [PC_W-1:0] bp_addr;
  logic phase;
  logic [PC_W-1:0] pc;
  logic cpu_en;
  logic halted;
  logic bp_hit;
  logic [CNT_W-1:0] instr_count;
  modport master (
    output run, halt, step, bp_en, bp_addr, phase, pc,
    input cpu_en, halted, bp_hit, instr_count
  );
  modport slave (
    input run, halt, step, bp_en, bp_addr, phase, pc,
    output cpu_en, halted, bp_hit, instr_count
  );
endinterface

// File: rtl/dbg_sat_counter.sv
// dbg_sat_counter: enabled up-counter that sticks at all-ones, async active-high reset
module dbg_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (en_i && !(&cnt_q)) cnt_q <= cnt_q + W'(1);
  assign cnt_o = cnt_q;
endmodule

// File: rtl/dbg_run_controller.sv
// dbg_run_controller: run/halt/step/breakpoint sequencer gating the Nibbler core clock enable.
// Define DBG_INSTR_COUNT_EN to build the retired-instruction counter; otherwise instr_count is 0.
module dbg_run_controller
  import dbg_run_controller_pkg::*;
#(
  parameter bit RESET_RUN = 1'b1,
  parameter int PC_W = PC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clock,
  input  logic reset,
  dbg_run_controller_if.slave dbg
);
  state_t state_q, state_d;
  logic skip_q, skip_d;
  logic bp_hit_q, bp_hit_d;
  logic bp_match, cpu_en;
  // skip_q masks the breakpoint until the instruction at bp_addr has executed once after a resume
  assign bp_match = dbg.bp_en & ~skip_q & ~dbg.phase & (PC_W'(dbg.pc) == PC_W'(dbg.bp_addr));
  assign cpu_en = (state_q == RUN) ? ~bp_match : (state_q == FINISH);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q  <= RESET_RUN ? RUN : HALT;
      skip_q   <= 1'b1;
      bp_hit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      bp_hit_q <= bp_hit_d;
    end
  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q & ~(cpu_en & dbg.phase);
    bp_hit_d = bp_hit_q;
    case (state_q)
      HALT:
        if (!dbg.halt && (dbg.run || dbg.step)) begin
          state_d  = dbg.run ? RUN : FINISH;
          skip_d   = 1'b1;
          bp_hit_d = 1'b0;
        end
      RUN:
        if (bp_match) begin
          state_d  = HALT;
          bp_hit_d = 1'b1;
        end else if (dbg.halt) state_d = dbg.phase ? HALT : FINISH;
      FINISH: state_d = dbg.phase ? HALT : FINISH;
      default: state_d = HALT;
    endcase
  end
  assign dbg.cpu_en = cpu_en;
  assign dbg.halted = (state_q == HALT);
  assign dbg.bp_hit = bp_hit_q;
`ifdef DBG_INSTR_COUNT_EN
  dbg_sat_counter #(.W(CNT_W)) u_cnt (
    .clk  (clock),
    .rst  (reset),
    .en_i (cpu_en & dbg.phase),
    .cnt_o(dbg.instr_count)
  );
`else
  assign dbg.instr_count = {CNT_W{1'b0}};
`endif
endmodule
